// File: rtl/pdp1_vga_pkg.sv
// Shared PDP-1 VGA definitions: default pixel/row-buffer widths and the intensity max used by blend and fade.
// Pure constants and functions; no latency, no flow control.
package pdp1_vga_pkg;

    localparam int PIX_W         = 8;
    localparam int ROWBUF_ADDR_W = 13;

    // Callers zero-extend narrower intensities; the compare is unsigned.
    function automatic logic [31:0] intensity_max(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pdp1_vga_rowbuffer_ram.sv
// Simple dual-port block RAM: one write port, one registered read port (read-before-write), no reset.
// Read data valid one cycle after re_i; rdata_o holds while re_i is low; never stalls.
module pdp1_vga_rowbuffer_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 13
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pdp1_vga_rowbuffer_blend.sv
// Scanout row buffer with max-blend writes, clear-on-read and a zero-fill sweep after reset; reads 1 cycle, writes visible 2 cycles after acceptance.
// wr_ready drops during the sweep and in the cycle a clear-on-read owns the write port.
module pdp1_vga_rowbuffer_blend
    import pdp1_vga_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int ADDR_W = ROWBUF_ADDR_W,
    parameter bit BLEND  = 1'b1
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic              rd_clear_i,
    output logic [DATA_W-1:0] rd_q_o,
    output logic              busy_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] fill_q, fill_d;
    logic              clr_pend_q, clr_pend_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              s2_vld_q, s2_vld_d;
    logic [ADDR_W-1:0] s2_addr_q, s2_addr_d;
    logic [DATA_W-1:0] s2_data_q, s2_data_d;
    logic              fwd_vld_q, fwd_vld_d;
    logic [DATA_W-1:0] fwd_q, fwd_d;
    logic              rd_seen_q, rd_seen_d;

    logic              accept, s2_stall, s2_fire, clr_hit, scan_re;
    logic [DATA_W-1:0] scan_dat, rmw_old_dat, s2_old, s2_res;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign s2_stall   = s2_vld_q && clr_pend_q;
    assign wr_ready_o = !busy_q && !clr_pend_q && !s2_stall;
    assign accept     = wr_valid_i && wr_ready_o;
    assign s2_fire    = s2_vld_q && !clr_pend_q && !busy_q;
    assign clr_hit    = s2_stall && (clr_addr_q == s2_addr_q);
    assign scan_re    = rd_en_i && !busy_q;
    assign busy_o     = busy_q;
    // The RAM output register has no reset; mask it until a real read has landed.
    assign rd_q_o     = rd_seen_q ? scan_dat : '0;

    always_comb begin
        s2_old = fwd_vld_q ? fwd_q : rmw_old_dat;
        s2_res = BLEND ? DATA_W'(intensity_max(32'(s2_old), 32'(s2_data_q))) : s2_data_q;
    end

    // Single write port: sweep, then clear, then the blend result.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = s2_addr_q;
        mem_wdata = s2_res;
        if (busy_q) begin
            mem_we    = 1'b1;
            mem_waddr = fill_q;
            mem_wdata = '0;
        end else if (clr_pend_q) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr_q;
            mem_wdata = '0;
        end else if (s2_vld_q) begin
            mem_we    = 1'b1;
        end
    end

    always_comb begin
        busy_d     = busy_q;
        fill_d     = fill_q;
        clr_pend_d = rd_en_i && rd_clear_i && !busy_q;
        clr_addr_d = rd_addr_i;
        rd_seen_d  = rd_seen_q || scan_re;
        s2_vld_d   = s2_vld_q;
        s2_addr_d  = s2_addr_q;
        s2_data_d  = s2_data_q;
        fwd_vld_d  = fwd_vld_q;
        fwd_d      = fwd_q;
        if (busy_q) begin
            fill_d = fill_q + ADDR_W'(1);
            if (fill_q == LAST_ADDR) begin
                busy_d = 1'b0;
            end
        end
        if (accept) begin
            // The RAM read issued now misses the result being written this cycle.
            s2_vld_d  = 1'b1;
            s2_addr_d = wr_addr_i;
            s2_data_d = wr_data_i;
            fwd_vld_d = s2_fire && (s2_addr_q == wr_addr_i);
            fwd_d     = s2_res;
        end else if (clr_hit) begin
            // The clear lands first, so the stalled blend must see zero.
            fwd_vld_d = 1'b1;
            fwd_d     = '0;
        end else if (s2_fire) begin
            s2_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            busy_q     <= 1'b1;
            fill_q     <= '0;
            clr_pend_q <= 1'b0;
            s2_vld_q   <= 1'b0;
            fwd_vld_q  <= 1'b0;
            rd_seen_q  <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            fill_q     <= fill_d;
            clr_pend_q <= clr_pend_d;
            s2_vld_q   <= s2_vld_d;
            fwd_vld_q  <= fwd_vld_d;
            rd_seen_q  <= rd_seen_d;
        end
    end

    always_ff @(posedge clock_i) begin
        clr_addr_q <= clr_addr_d;
        s2_addr_q  <= s2_addr_d;
        s2_data_q  <= s2_data_d;
        fwd_q      <= fwd_d;
    end

    pdp1_vga_rowbuffer_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_scan_ram (
        .clk_i   (clock_i),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .re_i    (scan_re),
        .raddr_i (rd_addr_i),
        .rdata_o (scan_dat)
    );

    // Mirror copy gives the RMW pipeline its own read port.
    pdp1_vga_rowbuffer_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_rmw_ram (
        .clk_i   (clock_i),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (mem_wdata),
        .re_i    (accept),
        .raddr_i (wr_addr_i),
        .rdata_o (rmw_old_dat)
    );

endmodule

// File: tb/tb_pdp1_vga_rowbuffer_blend.sv
// Bench for the blend row buffer: BLEND=1 and BLEND=0 instances share stimulus and are checked against an ordered-commit memory model.
module tb_pdp1_vga_rowbuffer_blend;

    localparam int DEPTH = 8192;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic        rd_en;
    logic [12:0] rd_addr;
    logic        rd_clear;
    logic        wr_ready1, busy1, wr_ready0, busy0;
    logic [7:0]  rd_q1, rd_q0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pdp1_vga_rowbuffer_blend #(.DATA_W(8), .ADDR_W(13), .BLEND(1'b1)) dut (
        .clock_i(clk), .reset_i(rst), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready1),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_clear_i(rd_clear), .rd_q_o(rd_q1), .busy_o(busy1)
    );

    pdp1_vga_rowbuffer_blend #(.DATA_W(8), .ADDR_W(13), .BLEND(1'b0)) dut_ow (
        .clock_i(clk), .reset_i(rst), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready0),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
        .rd_clear_i(rd_clear), .rd_q_o(rd_q0), .busy_o(busy0)
    );

    // Reference: memory contents per instance, plus the ordered list of pending commits.
    logic [7:0]  m1 [DEPTH];
    logic [7:0]  m0 [DEPTH];
    logic [7:0]  exp_q1, exp_q0;
    logic        known = 1'b0;
    logic        busy_m;
    int          sweep_cnt;
    logic        clr_pend_m;
    logic [12:0] clr_addr_m;
    logic        pw_vld;
    logic [12:0] pw_addr;
    logic [7:0]  pw_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic rs, input logic wv, input logic [12:0] wa, input logic [7:0] wd,
                        input logic re, input logic [12:0] ra, input logic rc);
        logic exp_rdy;
        logic acc;
        rst = rs; wr_valid = wv; wr_addr = wa; wr_data = wd;
        rd_en = re; rd_addr = ra; rd_clear = rc;
        exp_rdy = !busy_m && !clr_pend_m;
        acc     = known && !rs && wv && exp_rdy;
        if (known && !rs) begin
            chk("wr_ready_blend", 32'(wr_ready1), 32'(exp_rdy));
            chk("wr_ready_ovw", 32'(wr_ready0), 32'(exp_rdy));
        end
        @(posedge clk);
        #1;
        if (rs) begin
            known = 1'b1; busy_m = 1'b1; sweep_cnt = 0;
            clr_pend_m = 1'b0; pw_vld = 1'b0; exp_q1 = '0; exp_q0 = '0;
            for (int i = 0; i < DEPTH; i++) begin
                m1[i] = '0;
                m0[i] = '0;
            end
        end else if (known) begin
            if (re && !busy_m) begin
                exp_q1 = m1[ra];
                exp_q0 = m0[ra];
            end
            if (clr_pend_m) begin
                m1[clr_addr_m] = '0;
                m0[clr_addr_m] = '0;
            end else if (pw_vld) begin
                m1[pw_addr] = (m1[pw_addr] > pw_data) ? m1[pw_addr] : pw_data;
                m0[pw_addr] = pw_data;
                pw_vld = 1'b0;
            end
            clr_pend_m = re && rc && !busy_m;
            clr_addr_m = ra;
            if (acc) begin
                pw_vld = 1'b1; pw_addr = wa; pw_data = wd;
            end
            if (busy_m) begin
                sweep_cnt++;
                if (sweep_cnt == DEPTH) busy_m = 1'b0;
            end
        end
        if (known) begin
            chk("rd_q_blend", 32'(rd_q1), 32'(exp_q1));
            chk("rd_q_ovw", 32'(rd_q0), 32'(exp_q0));
            chk("busy_blend", 32'(busy1), 32'(busy_m));
            chk("busy_ovw", 32'(busy0), 32'(busy_m));
        end
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 13'd0, 8'd0, 1'b0, 13'd0, 1'b0);
    endtask

    task automatic wr(input logic [12:0] a, input logic [7:0] d);
        step(1'b0, 1'b1, a, d, 1'b0, 13'd0, 1'b0);
    endtask

    task automatic rd(input logic [12:0] a, input logic c);
        step(1'b0, 1'b0, 13'd0, 8'd0, 1'b1, a, c);
    endtask

    task automatic do_reset_and_sweep(input string tag);
        int busy_cnt;
        busy_cnt = 0;
        step(1'b1, 1'b0, 13'd0, 8'd0, 1'b0, 13'd0, 1'b0);
        chk({tag, "_rst_rdq"}, 32'(rd_q1), 32'h0);
        chk({tag, "_rst_ready"}, 32'(wr_ready1), 32'h0);
        for (int i = 0; i < DEPTH + 4; i++) begin
            if (busy1) busy_cnt++;
            idle();
        end
        chk({tag, "_busy_len"}, 32'(busy_cnt), 32'(DEPTH));
    endtask

    task automatic random_phase(input int n);
        logic [12:0] a;
        for (int i = 0; i < n; i++) begin
            a = ($urandom_range(0, 3) == 0) ? 13'($urandom_range(0, DEPTH - 1)) : 13'($urandom_range(0, 15));
            step(1'b0, 1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 13'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        rst = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; rd_clear = 1'b0;
        busy_m = 1'b0; clr_pend_m = 1'b0; pw_vld = 1'b0; sweep_cnt = 0;
        exp_q1 = '0; exp_q0 = '0;

        do_reset_and_sweep("sweep1");
        rd(13'd0, 1'b0);    chk("zero_a0", 32'(rd_q1), 32'h0);
        rd(13'd4095, 1'b0); chk("zero_a4095", 32'(rd_q1), 32'h0);
        rd(13'd8191, 1'b0); chk("zero_a8191", 32'(rd_q1), 32'h0);

        wr(13'd100, 8'h40); wr(13'd100, 8'h20); idle(); rd(13'd100, 1'b0);
        chk("blend_keep", 32'(rd_q1), 32'h40);
        chk("ovw_last", 32'(rd_q0), 32'h20);
        wr(13'd100, 8'hC0); idle(); rd(13'd100, 1'b0);
        chk("blend_raise", 32'(rd_q1), 32'hC0);

        wr(13'd7, 8'h10); wr(13'd7, 8'h80); wr(13'd7, 8'h30); idle(); rd(13'd7, 1'b0);
        chk("fwd_chain", 32'(rd_q1), 32'h80);
        chk("fwd_chain_ovw", 32'(rd_q0), 32'h30);

        wr(13'd5, 8'h55); idle(); rd(13'd5, 1'b1);
        chk("clr_read", 32'(rd_q1), 32'h55);
        chk("clr_wr_ready", 32'(wr_ready1), 32'h0);
        idle(); rd(13'd5, 1'b0);
        chk("clr_zero", 32'(rd_q1), 32'h0);

        wr(13'd9, 8'h77); idle();
        step(1'b0, 1'b1, 13'd9, 8'h33, 1'b1, 13'd9, 1'b1);
        chk("clr_conc_read", 32'(rd_q1), 32'h77);
        idle(); idle(); rd(13'd9, 1'b0);
        chk("clr_then_write", 32'(rd_q1), 32'h33);

        wr(13'd3, 8'h90); wr(13'd3, 8'h10); idle(); rd(13'd3, 1'b0);
        chk("ovw_3", 32'(rd_q0), 32'h10);
        chk("blend_3", 32'(rd_q1), 32'h90);

        random_phase(3000);

        wr(13'd11, 8'hFF);
        step(1'b1, 1'b0, 13'd0, 8'd0, 1'b0, 13'd0, 1'b0);
        for (int i = 0; i < 100; i++) idle();
        chk("mid_sweep_busy", 32'(busy1), 32'h1);
        do_reset_and_sweep("sweep2");
        rd(13'd11, 1'b0);
        chk("dropped_write", 32'(rd_q1), 32'h0);

        random_phase(1000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
